seg_scan_capture: RTL

- Receive-side counterpart of the 7-segment scan driver: samples the multiplexed active-low anode and segment lines, waits until each scan slot is stable, and decodes the segment pattern back to a hex nibble.
- Assembles the four digits into a frame with a valid/ack handshake.
- Used for loopback self-check of the display path and as a bench monitor in the UART engine.

---
 rtl/seg_scan_capture.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_capture.sv
// +------------------------------------------------------------------------+
// | seg_scan_capture: recovers hex digits from a scanned 7-segment bus.    |
// | Optional macro SEG_CAPTURE_DP_EN adds decimal-point capture. Rev 1.0   |
// +------------------------------------------------------------------------+
`default_nettype none

module seg_scan_capture #(
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
`ifdef SEG_CAPTURE_DP_EN
  input  logic        dp,
  output logic [3:0]  dp_bits,
`endif
  input  logic        frame_ack,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic        overrun,
  output logic        dec_err,
  output logic        seq_err
);

`ifdef SEG_CAPTURE_DP_EN
  localparam int W = 12;
`else
  localparam int W = 11;
`endif
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(STABLE_CNT);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(STABLE_CNT - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, COLLECT = 1'b1} state_t;

  logic [W-1:0]     raw, meta, sync, prev;
  logic [CNT_W-1:0] cnt;
  logic             cap;

`ifdef SEG_CAPTURE_DP_EN
  assign raw = {an, seg, dp};
`else
  assign raw = {an, seg};
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      meta <= '1;
      sync <= '1;
      prev <= '1;
      cnt  <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      prev <= sync;
      if (sync != prev)   cnt <= '0;
      else if (cnt != C_FULL) cnt <= cnt + 1'b1;
    end
  end

  // One strobe per stable period: only the step into saturation fires.
  assign cap = (sync == prev) && (cnt == C_LAST);

  logic [3:0] s_an;
  logic [6:0] s_seg;
  assign s_an  = sync[W-1 -: 4];
  assign s_seg = sync[W-5 -: 7];

  logic       blank, multi;
  logic [1:0] sel;
  always_comb begin
    blank = 1'b0;
    multi = 1'b0;
    sel   = 2'd0;
    case (s_an)
      4'b1110: sel = 2'd0;
      4'b1101: sel = 2'd1;
      4'b1011: sel = 2'd2;
      4'b0111: sel = 2'd3;
      4'b1111: blank = 1'b1;
      default: multi = 1'b1;
    endcase
  end

  logic       seg_ok;
  logic [3:0] nib;
  always_comb begin
    seg_ok = 1'b1;
    nib    = 4'h0;
    case (s_seg)
      7'h40: nib = 4'h0;  7'h79: nib = 4'h1;  7'h24: nib = 4'h2;  7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;  7'h12: nib = 4'h5;  7'h02: nib = 4'h6;  7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;  7'h10: nib = 4'h9;  7'h08: nib = 4'hA;  7'h03: nib = 4'hB;
      7'h46: nib = 4'hC;  7'h21: nib = 4'hD;  7'h06: nib = 4'hE;  7'h0E: nib = 4'hF;
      default: seg_ok = 1'b0;
    endcase
  end

  state_t          state, state_n;
  logic [1:0]      exp_sel, exp_sel_n;
  logic [2:0][3:0] shadow, shadow_n;
  logic [15:0]     digits_n;
  logic            valid_n, overrun_n, dec_n, seq_n;
`ifdef SEG_CAPTURE_DP_EN
  logic [2:0] dp_sh, dp_sh_n;
  logic [3:0] dp_bits_n;
  logic       lit;
  assign lit = ~sync[0];
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= IDLE;
      exp_sel     <= 2'd0;
      shadow      <= '0;
      digits      <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      dec_err     <= 1'b0;
      seq_err     <= 1'b0;
`ifdef SEG_CAPTURE_DP_EN
      dp_sh       <= '0;
      dp_bits     <= '0;
`endif
    end else begin
      state       <= state_n;
      exp_sel     <= exp_sel_n;
      shadow      <= shadow_n;
      digits      <= digits_n;
      frame_valid <= valid_n;
      overrun     <= overrun_n;
      dec_err     <= dec_n;
      seq_err     <= seq_n;
`ifdef SEG_CAPTURE_DP_EN
      dp_sh       <= dp_sh_n;
      dp_bits     <= dp_bits_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    exp_sel_n = exp_sel;
    shadow_n  = shadow;
    digits_n  = digits;
    valid_n   = frame_valid & ~frame_ack;
    overrun_n = overrun & ~frame_ack;
    dec_n     = 1'b0;
    seq_n     = 1'b0;
`ifdef SEG_CAPTURE_DP_EN
    dp_sh_n   = dp_sh;
    dp_bits_n = dp_bits;
`endif
    if (cap && !blank) begin
      if (multi || !seg_ok) begin
        dec_n   = 1'b1;
        state_n = IDLE;
      end else if (state == IDLE || (sel != exp_sel && sel == 2'd0)) begin
        // Slot 0 always (re)starts a frame; out-of-order restarts also flag.
        seq_n = (state == COLLECT);
        if (sel == 2'd0) begin
          shadow_n[0] = nib;
          exp_sel_n   = 2'd1;
          state_n     = COLLECT;
`ifdef SEG_CAPTURE_DP_EN
          dp_sh_n[0]  = lit;
`endif
        end
      end else if (sel != exp_sel) begin
        seq_n   = 1'b1;
        state_n = IDLE;
      end else if (exp_sel == 2'd3) begin
        digits_n  = {nib, shadow[2], shadow[1], shadow[0]};
        valid_n   = 1'b1;
        overrun_n = overrun_n | (frame_valid & ~frame_ack);
        state_n   = IDLE;
`ifdef SEG_CAPTURE_DP_EN
        dp_bits_n = {lit, dp_sh};
`endif
      end else begin
        shadow_n[exp_sel] = nib;
        exp_sel_n         = exp_sel + 2'd1;
`ifdef SEG_CAPTURE_DP_EN
        dp_sh_n[exp_sel]  = lit;
`endif
      end
    end
  end

endmodule

`default_nettype wire
